// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state codes, default timing constants and
// the debug view of the transmitter, reused by the PS/2 receiver.
package ps2_pkg;

  localparam int INHIBIT_CYCLES_DEF = 10000;
  localparam int TIMEOUT_CYCLES_DEF = 2000000;
  localparam int FIFO_DEPTH_DEF     = 4;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_RTS       = 3'd2;
  localparam logic [2:0] ST_DATA      = 3'd3;
  localparam logic [2:0] ST_PARITY    = 3'd4;
  localparam logic [2:0] ST_STOP      = 3'd5;
  localparam logic [2:0] ST_ACK       = 3'd6;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd7;

  typedef struct packed {
    logic [2:0] state;
    logic [3:0] bit_idx;
    logic       ack_ok;
  } ps2_tx_dbg_t;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Command byte FIFO for the PS/2 transmitter: show-ahead read data,
// registered pointers that wrap modulo DEPTH (DEPTH must be a power of two, >= 2).
module ps2_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Full is judged on the pre-pop count, so a push while full is dropped
  // even if a pop happens on the same cycle.
  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: queues command bytes and sends each as an
// inhibit / request-to-send / 11-bit frame, reporting done or err per byte.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
  input  logic        clock,
  input  logic        reset,
  // Handshake: a byte transfers on every rising edge where tx_valid && tx_ready;
  // tx_ready never depends on tx_valid, and tx_data only matters while tx_valid.
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic        ps2_clk_oe,
  output logic        ps2_dat_oe,
  output logic        busy,
  output logic        done,
  output logic        err,
  output ps2_tx_dbg_t dbg
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LOAD = CNT_W'(INHIBIT_CYCLES);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       LAST_BIT = 4'd8;

  logic [2:0]       state_q, state_d;
  logic [2:0]       clk_sync_q, clk_sync_d;
  logic [2:0]       dat_sync_q, dat_sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       shift_q, shift_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             ack_ok_q, ack_ok_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             fifo_pop;
  logic [7:0]       fifo_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fall;
  logic             clk_s;
  logic             dat_s;

  ps2_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign clk_sync_d = {clk_sync_q[1:0], ps2_clk};
  assign dat_sync_d = {dat_sync_q[1:0], ps2_dat};
  assign fall       = clk_sync_q[2] & ~clk_sync_q[1];
  assign clk_s      = clk_sync_q[1];
  assign dat_s      = dat_sync_q[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    dat_oe_d  = dat_oe_q;
    ack_ok_d  = ack_ok_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dat_oe_d = 1'b0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = {odd_parity(fifo_data), fifo_data};
          cnt_d    = INH_LOAD;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        // Leave on the count of one so ps2_clk is held low exactly INHIBIT_CYCLES.
        if (cnt_q <= CNT_ONE) begin
          dat_oe_d = 1'b1;
          cnt_d    = TO_LOAD;
          state_d  = ST_RTS;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RTS, ST_DATA, ST_PARITY, ST_STOP: begin
        if (fall) begin
          cnt_d = TO_LOAD;
          case (state_q)
            ST_RTS: begin
              dat_oe_d  = ~shift_q[0];
              bit_idx_d = 4'd1;
              state_d   = ST_DATA;
            end
            ST_DATA: begin
              // shift_q[8] is the parity bit, so index 8 ends the data phase.
              dat_oe_d = ~shift_q[bit_idx_q];
              if (bit_idx_q == LAST_BIT) begin
                state_d = ST_PARITY;
              end else begin
                bit_idx_d = bit_idx_q + 4'd1;
              end
            end
            ST_PARITY: begin
              dat_oe_d = 1'b0;
              state_d  = ST_STOP;
            end
            default: begin
              ack_ok_d = ~dat_s;
              state_d  = ST_ACK;
            end
          endcase
        end else if (cnt_q == '0) begin
          dat_oe_d = 1'b0;
          err_d    = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_ACK: begin
        dat_oe_d = 1'b0;
        done_d   = ack_ok_q;
        err_d    = ~ack_ok_q;
        cnt_d    = TO_LOAD;
        state_d  = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        dat_oe_d = 1'b0;
        // The byte's outcome was already reported in ACK; a stuck bus here
        // only abandons the wait, keeping done/err to one pulse per byte.
        if (clk_s && dat_s) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        dat_oe_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
    clk_oe_d = (state_d == ST_INHIBIT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      clk_sync_q <= 3'b111;
      dat_sync_q <= 3'b111;
      cnt_q      <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      ack_ok_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      ack_ok_q   <= ack_ok_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign tx_ready    = !fifo_full;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_dat_oe  = dat_oe_q;
  assign busy        = (state_q != ST_IDLE) || !fifo_empty;
  assign done        = done_q;
  assign err         = err_q;
  assign dbg.state   = state_q;
  assign dbg.bit_idx = bit_idx_q;
  assign dbg.ack_ok  = ack_ok_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a PS/2 device model clocks frames out of the DUT and a
// byte-level reference checks framing, parity, inhibit length and outcomes.
module tb_ps2_tx;
  import ps2_pkg::*;

  localparam int INH   = 50;
  localparam int TO    = 400;
  localparam int DEPTH = 4;
  localparam int H     = 16;
  localparam int NVEC  = 9;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_ready;
  logic        ps2_clk_oe, ps2_dat_oe;
  logic        busy, done, err;
  ps2_tx_dbg_t dbg;
  logic        dev_clk_low = 1'b0;
  logic        dev_dat_low = 1'b0;
  logic        clk_line, dat_line;

  assign clk_line = ~(ps2_clk_oe | dev_clk_low);
  assign dat_line = ~(ps2_dat_oe | dev_dat_low);

  ps2_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .ps2_clk    (clk_line),
    .ps2_dat    (dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg        (dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, wide_cnt = 0;
  logic done_prev = 1'b0, err_prev = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0]  data;
    bit          ack;
    logic [10:0] exp_bits;
    bit          exp_done;
  } vec_t;
  vec_t vecs[NVEC];

  always @(negedge clock) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_cnt++;
    if ((done && done_prev) || (err && err_prev)) wide_cnt++;
    done_prev = done;
    err_prev  = err;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame as seen on the wire: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    int ones = 0;
    logic par;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    par = (ones % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b, 1'b0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clock);
    tx_valid = 1'b1;
    tx_data  = b;
    while (!tx_ready && n < 20000) begin
      @(negedge clock);
      n++;
    end
    check("push_accept", {31'd0, tx_ready}, 32'd1);
    @(negedge clock);
    tx_valid = 1'b0;
    exp_q.push_back(b);
  endtask

  task automatic device_frame(input int falls, input bit ack,
                              output logic [10:0] bits, output int inh_len);
    int n = 0;
    bits    = '0;
    inh_len = 0;
    while (!ps2_clk_oe && n < 20000) begin
      @(negedge clock);
      n++;
    end
    check("inhibit_seen", {31'd0, ps2_clk_oe}, 32'd1);
    while (ps2_clk_oe && inh_len < 20000) begin
      inh_len++;
      @(negedge clock);
    end
    n = 0;
    while (!(clk_line && !dat_line) && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check("rts_seen", {31'd0, (clk_line && !dat_line)}, 32'd1);
    repeat (H) @(negedge clock);
    bits[0] = dat_line;
    for (int k = 1; k <= falls; k++) begin
      if (k == 11 && ack) begin
        dev_dat_low = 1'b1;
        repeat (H / 2) @(negedge clock);
      end
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clock);
      dev_clk_low = 1'b0;
      repeat (H) @(negedge clock);
      if (k <= 10) bits[k] = dat_line;
    end
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(dbg.state == ST_IDLE && !busy) && n < 5000) begin
      @(negedge clock);
      n++;
    end
    check(name, {31'd0, (dbg.state == ST_IDLE && !busy)}, 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [10:0] bits;
    logic [10:0] fb;
    logic [7:0]  exp_b;
    logic [7:0]  ta, tb_b;
    logic [7:0]  fifo_bytes [5];
    int          inh;
    int          d0, e0, c, total;

    vecs[0] = '{8'hED, 1'b1, 11'b1_1_11101101_0, 1'b1};
    vecs[1] = '{8'h07, 1'b1, 11'b1_0_00000111_0, 1'b1};
    vecs[2] = '{8'hFF, 1'b1, 11'b1_1_11111111_0, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 11'b1_1_00000000_0, 1'b1};
    vecs[4] = '{8'hED, 1'b0, 11'b1_1_11101101_0, 1'b0};
    for (int i = 5; i < NVEC; i++) begin
      vecs[i].data     = 8'($urandom_range(0, 255));
      vecs[i].ack      = ($urandom_range(0, 3) != 0);
      vecs[i].exp_bits = frame_bits(vecs[i].data);
      vecs[i].exp_done = vecs[i].ack;
    end

    repeat (3) @(negedge clock);
    check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("rst_state", {29'd0, dbg.state}, {29'd0, ST_IDLE});
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Table-driven single frames.
    for (int i = 0; i < NVEC; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      push_byte(vecs[i].data);
      device_frame(11, vecs[i].ack, bits, inh);
      wait_idle($sformatf("v%0d_idle", i));
      exp_b = exp_q.pop_front();
      check($sformatf("v%0d_inhibit_len", i), inh, INH);
      check($sformatf("v%0d_bits", i), {21'd0, bits}, {21'd0, vecs[i].exp_bits});
      check($sformatf("v%0d_rx_byte", i), {24'd0, bits[8:1]}, {24'd0, exp_b});
      check($sformatf("v%0d_done", i), done_cnt - d0, vecs[i].exp_done ? 1 : 0);
      check($sformatf("v%0d_err", i), err_cnt - e0, vecs[i].exp_done ? 0 : 1);
    end

    // Device stops clocking after four bits; the next queued byte must follow cleanly.
    d0 = done_cnt;
    e0 = err_cnt;
    ta   = 8'($urandom_range(0, 255));
    tb_b = 8'($urandom_range(0, 255));
    push_byte(ta);
    push_byte(tb_b);
    device_frame(4, 1'b1, bits, inh);
    c = 0;
    while (!err && c < 2 * TO) begin
      @(negedge clock);
      c++;
    end
    total = 2 * H + c;
    check("timeout_window", {31'd0, (total >= TO && total <= TO + 12)}, 32'd1);
    check("timeout_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    fb = frame_bits(ta);
    check("timeout_partial", {27'd0, bits[4:0]}, {27'd0, fb[4:0]});
    void'(exp_q.pop_front());
    device_frame(11, 1'b1, bits, inh);
    wait_idle("timeout_next_idle");
    exp_b = exp_q.pop_front();
    check("timeout_next_bits", {21'd0, bits}, {21'd0, frame_bits(exp_b)});
    check("timeout_err", err_cnt - e0, 1);
    check("timeout_done", done_cnt - d0, 1);

    // Five back-to-back pushes: the first is popped at once, the next four fill the FIFO.
    d0 = done_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 5; i++) fifo_bytes[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      tx_valid = 1'b1;
      tx_data  = fifo_bytes[i];
      check($sformatf("fifo_ready_%0d", i), {31'd0, tx_ready}, 32'd1);
      exp_q.push_back(fifo_bytes[i]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      tx_data = 8'h5A;
      check($sformatf("fifo_full_%0d", i), {31'd0, tx_ready}, 32'd0);
    end
    tx_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      device_frame(11, 1'b1, bits, inh);
      exp_b = exp_q.pop_front();
      check($sformatf("fifo_order_%0d", i), {21'd0, bits}, {21'd0, frame_bits(exp_b)});
    end
    wait_idle("fifo_idle");
    check("fifo_done", done_cnt - d0, 5);
    check("fifo_err", err_cnt - e0, 0);

    // Reset in the middle of the data bits, with a second byte still queued.
    d0 = done_cnt;
    e0 = err_cnt;
    push_byte(8'h3C);
    push_byte(8'hA5);
    device_frame(3, 1'b1, bits, inh);
    check("mid_state", {29'd0, dbg.state}, {29'd0, ST_DATA});
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    repeat (50) @(negedge clock);
    check("mid_rst_busy_after", {31'd0, busy}, 32'd0);
    check("mid_rst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);

    check("done_err_overlap", both_cnt, 0);
    check("pulse_width", wide_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 10000: clock cycles ps2_clk is held low before request-to-send (100 us at 100 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 2000000: maximum clock cycles the block waits for any expected device edge.
REQ-003 Parameter FIFO_DEPTH, default 4: command byte FIFO entries; power of two.
REQ-004 clock  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 tx_valid  in  1  command byte offered.
REQ-007 tx_data  in  8  command byte; transmitted LSB first.
REQ-008 tx_ready  out  1  FIFO not full; a byte is accepted on a cycle with tx_valid && tx_ready.
REQ-009 ps2_clk  in  1  PS/2 clock line level (asynchronous).
REQ-010 ps2_dat  in  1  PS/2 data line level (asynchronous).
REQ-011 ps2_clk_oe  out  1  1 = pull ps2_clk low (open drain); 0 = release.
REQ-012 ps2_dat_oe  out  1  1 = pull ps2_dat low; 0 = release.
REQ-013 busy  out  1  FSM not in IDLE, or FIFO not empty.
REQ-014 done  out  1  one-cycle pulse: frame ended with valid ack.
REQ-015 err  out  1  one-cycle pulse: frame aborted (no ack or timeout).

Function
REQ-016 ps2_clk and ps2_dat SHALL each pass a 3-flop synchronizer; fall = sync[2] & ~sync[1]; all protocol decisions use synchronized values only.
REQ-017 FSM states: IDLE, INHIBIT, RTS, DATA, PARITY, STOP, ACK, WAIT_IDLE.
REQ-018 IDLE: when FIFO non-empty, pop head into shift register, compute odd parity (~^byte), load counter with INHIBIT_CYCLES, go INHIBIT next cycle.
REQ-019 INHIBIT: ps2_clk_oe=1, ps2_dat_oe=0; counter decrements each cycle; at zero, assert ps2_dat_oe=1 and go RTS.
REQ-020 RTS: ps2_clk_oe=0 (released), ps2_dat_oe=1 (start bit 0); on first fall, drive bit0 (ps2_dat_oe = ~bit0), go DATA with bit index 1.
REQ-021 DATA: on each fall, drive next bit (oe = ~bit); after bit7 driven, next fall drives parity and goes PARITY.
REQ-022 PARITY: on fall, release ps2_dat (stop bit 1), go STOP.
REQ-023 STOP: on fall, go ACK and sample synchronized ps2_dat on that same cycle: 0 -> ack ok, 1 -> ack fail.
REQ-024 ACK: go WAIT_IDLE; pulse done if ack ok, else pulse err.
REQ-025 WAIT_IDLE: both oe=0; return to IDLE when synchronized ps2_clk and ps2_dat are both 1.
REQ-026 In RTS/DATA/PARITY/STOP/WAIT_IDLE a timeout counter reloads with TIMEOUT_CYCLES on every fall (WAIT_IDLE: on entry) and decrements otherwise; at zero: both oe=0, err pulses one cycle, go IDLE; byte discarded, no retry.
REQ-027 done and err SHALL never assert on the same cycle; exactly one of them pulses per popped byte.
REQ-028 FIFO: simultaneous push and pop on a full FIFO is allowed (pop frees the slot the same cycle only if tx_ready was computed from pre-pop count: tx_ready = count != FIFO_DEPTH; push on full is ignored).
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-030 At most one byte in flight; FIFO pops only in IDLE.

Reset
REQ-031 On reset: FSM=IDLE, FIFO empty, ps2_clk_oe=0, ps2_dat_oe=0, tx_ready=1, busy=0, done=0, err=0, synchronizer flops=1.
REQ-032 Reset mid-frame SHALL release both lines the next cycle and discard the in-flight byte and FIFO contents without pulsing done or err.

Structure
REQ-033 State encoding and default parameter constants SHALL live in shared package ps2_pkg, also used by the receiver.
REQ-034 FIFO SHALL be a sub-module ps2_tx_fifo (synchronous, registered pointers); FSM, synchronizers and counters stay in ps2_tx.

Verification
REQ-035 Push 0xED with device model acking -> ps2_clk_oe held low INHIBIT_CYCLES, line bits 0,1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once.
REQ-036 Push 0x07 -> parity bit 0; push 0xFF and 0x00 -> parity 1 each; done pulses per byte.
REQ-037 Device model leaves ps2_dat high at 11th fall -> err pulses once, done never, FSM returns IDLE after lines high.
REQ-038 Device stops clocking after 4 bits -> err after TIMEOUT_CYCLES, both oe=0, next queued byte then sent correctly.
REQ-039 Push 5 bytes back-to-back with FIFO_DEPTH=4 while first frame pending -> tx_ready deasserts exactly when 4 are queued; all accepted bytes sent in order.
REQ-040 Assert reset during DATA -> next cycle oe both 0, busy 0, no done/err pulse.
